// File: rtl/prog_loader_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_mem
// Description : 2^ADDR_W x 16 program/data memory for the 8-bit accumulator
//               processor, with a byte-stream boot loader. The loader fills
//               memory from a valid/ready byte stream (count header, hi/lo
//               word bytes, 8-bit wrapping checksum). It holds the processor
//               in reset until a load with a matching checksum completes.
// Ports       : clk_i        system clock, rising edge
//               clr_i        asynchronous active-low reset
//               ld_data_i    loader byte
//               ld_valid_i   loader byte valid
//               ld_ready_o   loader accepts a byte (from state only)
//               adrs_i       processor address
//               rw_i         processor direction, 1 = read, 0 = write
//               dout_i       processor write data (low byte)
//               din_o        processor read data, mem[adrs_i] (asynchronous)
//               cpu_clr_o    active-low processor reset, 1 only in RUN
//               load_done_o  high in RUN
//               load_err_o   high in ERR
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [7:0]        ld_data_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] adrs_i,
  input  logic              rw_i,
  input  logic [7:0]        dout_i,
  output logic [15:0]       din_o,
  output logic              cpu_clr_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR = 3'd0,
    S_HI  = 3'd1,
    S_LO  = 3'd2,
    S_CHK = 3'd3,
    S_RUN = 3'd4,
    S_ERR = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [7:0]        sum_q;
  logic [7:0]        hi_q;
  logic              cpu_clr_q;
  logic              load_done_q;
  logic              load_err_q;

  logic [15:0]       mem_q [0:DEPTH-1];

  logic              w_accept;
  logic              w_ld_wr;
  logic              w_cpu_wr;

  // Ready depends on state only, so there is no path from ld_valid_i back
  // to ld_ready_o.
  assign ld_ready_o = (state_q != S_RUN) && (state_q != S_ERR);
  assign w_accept   = ld_valid_i && ld_ready_o;
  assign w_ld_wr    = w_accept && (state_q == S_LO);
  // Loader and processor writes live in exclusive states, never both at once.
  assign w_cpu_wr   = (state_q == S_RUN) && !rw_i;

  // Loader FSM with registered state-decode outputs.
  always_ff @(posedge clk_i or negedge clr_i) begin
    if (!clr_i) begin
      state_q     <= S_HDR;
      wr_addr_q   <= '0;
      last_q      <= '0;
      sum_q       <= '0;
      hi_q        <= '0;
      cpu_clr_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else if (w_accept) begin
      case (state_q)
        S_HDR: begin
          // Header holds (word count - 1), i.e. the index of the last word.
          last_q    <= ADDR_W'(ld_data_i);
          wr_addr_q <= '0;
          sum_q     <= ld_data_i;
          state_q   <= S_HI;
        end
        S_HI: begin
          hi_q    <= ld_data_i;
          sum_q   <= sum_q + ld_data_i;
          state_q <= S_LO;
        end
        S_LO: begin
          sum_q <= sum_q + ld_data_i;
          // Exit on the last index rather than on a wrap, so a full-depth
          // load ends at the top address without rolling over to 0.
          if (wr_addr_q == last_q) begin
            state_q <= S_CHK;
          end else begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            state_q   <= S_HI;
          end
        end
        S_CHK: begin
          if (ld_data_i == sum_q) begin
            state_q     <= S_RUN;
            cpu_clr_q   <= 1'b1;
            load_done_q <= 1'b1;
          end else begin
            state_q    <= S_ERR;
            load_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Memory is intentionally not reset: contents survive clr_i, including a
  // partially written load.
  always_ff @(posedge clk_i) begin
    if (w_ld_wr) begin
      mem_q[wr_addr_q] <= {hi_q, ld_data_i};
    end else if (w_cpu_wr) begin
      mem_q[adrs_i][7:0] <= dout_i;
    end
  end

  assign din_o       = mem_q[adrs_i];
  assign cpu_clr_o   = cpu_clr_q;
  assign load_done_o = load_done_q;
  assign load_err_o  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader_mem
// Description : Directed self-checking bench for prog_loader_mem. Inputs are
//               driven after the falling edge, outputs sampled before the
//               next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader_mem;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              clr;
  logic [7:0]        ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] adrs;
  logic              rw;
  logic [7:0]        dout;
  logic [15:0]       din;
  logic              cpu_clr;
  logic              load_done;
  logic              load_err;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader_mem #(.ADDR_W(ADDR_W)) u_dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .ld_data_i   (ld_data),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .adrs_i      (adrs),
    .rw_i        (rw),
    .dout_i      (dout),
    .din_o       (din),
    .cpu_clr_o   (cpu_clr),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge.
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    ld_data  = b;
    ld_valid = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clr = 1'b0;
    #2;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    @(negedge clk);
    adrs = a;
    #1;
    check(tag, din, exp);
  endtask

  logic [7:0] sum;
  logic [7:0] lo_b;

  initial begin
    clr      = 1'b0;
    ld_data  = 8'h00;
    ld_valid = 1'b0;
    adrs     = '0;
    rw       = 1'b1;
    dout     = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_clr",   {15'd0, cpu_clr},   16'd0);
    check("rst_load_done", {15'd0, load_done}, 16'd0);
    check("rst_load_err",  {15'd0, load_err},  16'd0);
    check("rst_ld_ready",  {15'd0, ld_ready},  16'd1);
    clr = 1'b1;

    // Two-word load, checksum 01+12+34+56+78 = 0x15
    push(8'h01); push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    @(negedge clk);
    check("t1_pre_chk_cpu_clr", {15'd0, cpu_clr}, 16'd0);
    check("t1_pre_chk_ready",   {15'd0, ld_ready}, 16'd1);
    push(8'h15);
    @(negedge clk);
    check("t1_cpu_clr",   {15'd0, cpu_clr},   16'd1);
    check("t1_load_done", {15'd0, load_done}, 16'd1);
    check("t1_ld_ready",  {15'd0, ld_ready},  16'd0);
    check("t1_load_err",  {15'd0, load_err},  16'd0);
    read_chk("t1_mem0", 8'd0, 16'h1234);
    read_chk("t1_mem1", 8'd1, 16'h5678);
    push(8'h99);   // ignored in RUN
    @(negedge clk);
    check("t1_run_sticky", {15'd0, load_done}, 16'd1);
    read_chk("t1_mem0_after_extra", 8'd0, 16'h1234);

    // Bad checksum: 01+11+22+33+44 = 0xAB, send 0xAC
    reset_dut();
    check("t2_rst_done", {15'd0, load_done}, 16'd0);
    push(8'h01); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'hAC);
    @(negedge clk);
    check("t2_load_err", {15'd0, load_err}, 16'd1);
    check("t2_cpu_clr",  {15'd0, cpu_clr},  16'd0);
    check("t2_ld_ready", {15'd0, ld_ready}, 16'd0);
    read_chk("t2_mem0", 8'd0, 16'h1122);
    read_chk("t2_mem1", 8'd1, 16'h3344);
    @(negedge clk);
    clr = 1'b0;
    #2;
    check("t2_clr_err",   {15'd0, load_err}, 16'd0);
    check("t2_clr_ready", {15'd0, ld_ready}, 16'd1);
    @(negedge clk);
    clr = 1'b1;

    // Handshake gaps
    push(8'h01); idle(2);
    push(8'h12); idle(2);
    push(8'h34); idle(2);
    push(8'h56); idle(2);
    push(8'h78); idle(2);
    @(negedge clk);
    check("t3_gap_not_done", {15'd0, load_done}, 16'd0);
    push(8'h15);
    @(negedge clk);
    check("t3_load_done", {15'd0, load_done}, 16'd1);
    check("t3_cpu_clr",   {15'd0, cpu_clr},   16'd1);
    read_chk("t3_mem0", 8'd0, 16'h1234);
    read_chk("t3_mem1", 8'd1, 16'h5678);

    // Reset mid-load, then one-word load: 00+AB+CD = 0x78
    reset_dut();
    push(8'h01); push(8'h12); push(8'h34);
    reset_dut();
    push(8'h00); push(8'hAB); push(8'hCD);
    @(negedge clk);
    check("t4_pre_chk_done", {15'd0, load_done}, 16'd0);
    push(8'h78);
    @(negedge clk);
    check("t4_load_done", {15'd0, load_done}, 16'd1);
    check("t4_load_err",  {15'd0, load_err},  16'd0);
    read_chk("t4_mem0", 8'd0, 16'hABCD);

    // Full depth: 256 words, word i = {i, ~i}
    reset_dut();
    sum = 8'hFF;
    push(8'hFF);
    for (int i = 0; i < 256; i++) begin
      lo_b = ~i[7:0];
      push(i[7:0]);
      push(lo_b);
      sum = sum + i[7:0] + lo_b;
    end
    @(negedge clk);
    check("t5_no_early_exit", {15'd0, load_done}, 16'd0);
    check("t5_ready_chk",     {15'd0, ld_ready},  16'd1);
    push(sum);
    @(negedge clk);
    check("t5_load_done", {15'd0, load_done}, 16'd1);
    read_chk("t5_mem255", 8'd255, 16'hFF00);
    read_chk("t5_mem0",   8'd0,   16'h00FF);
    read_chk("t5_mem128", 8'd128, 16'h807F);

    // Processor write: load 6 words, word5 = 0x2A00, checksum 05+2A = 0x2F
    reset_dut();
    push(8'h05);
    for (int i = 0; i < 5; i++) begin
      push(8'h00);
      push(8'h00);
    end
    push(8'h2A); push(8'h00); push(8'h2F);
    @(negedge clk);
    check("t6_load_done", {15'd0, load_done}, 16'd1);
    read_chk("t6_mem5_init", 8'd5, 16'h2A00);
    @(negedge clk);
    adrs = 8'd5;
    dout = 8'h3C;
    rw   = 1'b0;
    #1;
    check("t6_same_cycle_old", din, 16'h2A00);
    @(posedge clk);
    #1;
    rw = 1'b1;
    check("t6_mem5_written", din, 16'h2A3C);
    read_chk("t6_mem4_untouched", 8'd4, 16'h0000);

    // Same write attempted in HDR is ignored
    reset_dut();
    @(negedge clk);
    adrs = 8'd5;
    dout = 8'h55;
    rw   = 1'b0;
    @(posedge clk);
    #1;
    rw = 1'b1;
    read_chk("t6_hdr_write_ignored", 8'd5, 16'h2A3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader_mem.md
# prog_loader_mem

Program/data memory plus boot loader for the 8-bit accumulator processor. It holds a 256 x 16 memory that serves the processor's `din`/`adrs`/`rw`/`dout` bus. It fills that memory from an external byte stream using a valid/ready handshake, and holds the processor in reset through `cpu_clr` until a checksummed load has completed. It sits directly on the processor's memory side: it consumes `adrs`, `rw` and `dout`, and produces `din`.

## Interface
- `ADDR_W`, default 8: address width. Memory depth is 2^ADDR_W words of 16 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ld_data`  in  8  loader byte.
- `ld_valid`  in  1  `ld_data` is valid this cycle.
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `adrs`  in  ADDR_W  processor address.
- `rw`  in  1  processor direction: 1 = read, 0 = write.
- `dout`  in  8  processor write data (accumulator).
- `din`  out  16  processor read data: `mem[adrs]`.
- `cpu_clr`  out  1  active-low reset to the processor; 1 only in RUN.
- `load_done`  out  1  high in RUN.
- `load_err`  out  1  high in ERR.

## Operation
- A byte is accepted on a rising edge where `ld_valid && ld_ready`. All counters and state advance only on accepted bytes.
- FSM states are HDR, HI, LO, CHK, RUN and ERR. Reset enters HDR.
- `ld_ready` is 1 in HDR, HI, LO and CHK. It is 0 in RUN and ERR.
- **HDR**
  - Accept the count byte: `last <= ld_data`, meaning the load is `ld_data + 1` words (1..256).
  - `wr_addr <= 0`; `sum <= ld_data`.
  - Go to HI.
- **HI**
  - `hi <= ld_data`; `sum <= sum + ld_data`.
  - Go to LO.
- **LO**
  - `mem[wr_addr] <= {hi, ld_data}` on the same edge; `sum <= sum + ld_data`.
  - If `wr_addr == last`, go to CHK. Otherwise `wr_addr <= wr_addr + 1` and go to HI.
- **CHK**
  - If `ld_data == sum`, go to RUN. Otherwise go to ERR.
  - The checksum byte itself is not added to `sum`.
- **RUN**
  - `cpu_clr = 1`; `load_done = 1`.
  - Further `ld_valid` is ignored.
- **ERR**
  - `cpu_clr = 0`; `load_err = 1`.
  - Exits only via `clr`.
- Sums are 8-bit and wrap modulo 256. `wr_addr` is ADDR_W bits. With `last = 0xFF`, the LO→CHK exit happens at `wr_addr = 0xFF`; the address never wraps to 0.
- **Processor read**
  - `din = mem[adrs]`, combinational and asynchronous, in every state.
  - Unwritten locations return whatever contents they hold; the memory is not reset.
- **Processor write**
  - Only in RUN: on an edge with `rw == 0`, `mem[adrs][7:0] <= dout`.
  - The high byte `[15:8]` is preserved.
  - Writes outside RUN are ignored.
  - Loader and processor writes cannot coincide, because they occur in exclusive states.
- **Reset**
  - `clr` low at any time forces state HDR, `wr_addr = 0`, `sum = 0`, `hi = 0`, `last = 0`.
  - Memory contents are retained, including a partially written load.

## Timing
- Reset values:
  - `cpu_clr = 0`, `load_done = 0`, `load_err = 0`, `ld_ready = 1`.
  - `din` follows `mem[adrs]`.
- `cpu_clr`, `load_done` and `load_err` are registered state decodes. `cpu_clr` rises on the edge that accepts a matching checksum byte.
- The processor sees its first clock with `cpu_clr = 1` on the next edge after that.
- A loaded word is readable on `din` immediately after the LO edge that writes it.
- A processor write is visible on `din` after the write edge. A same-cycle read returns the old value.
- `ld_ready` is combinational from state only, never from `ld_valid`, so there is no combinational loop to the source.
- Throughput: one byte per cycle. A load of N words takes 2N + 2 accepted bytes.
- Idle cycles (`ld_valid = 0`) stall the FSM without any state change.

## Test plan
- **Two-word load.** Stream 01, 12, 34, 56, 78, 15 back-to-back.
  - Required: `mem[0] = 0x1234`, `mem[1] = 0x5678`.
  - `cpu_clr` and `load_done` are 1 after the 6th byte; `ld_ready` goes to 0.
  - With `adrs = 1`: `din = 0x5678`.
- **Bad checksum.** Same stream ending in 0x16.
  - Required: `load_err = 1`, `cpu_clr` stays 0, `ld_ready = 0`.
  - `mem[0..1]` are still written.
  - Then `clr` low → HDR, `load_err = 0`.
- **Handshake gaps.** Same stream as the two-word load with `ld_valid` toggling 1,0,0,1….
  - Required: identical final memory and RUN entry.
  - No byte is lost or duplicated.
- **Reset mid-load.** Assert `clr` after 3 accepted bytes, then send a full one-word load: 00, AB, CD, 78.
  - Required: `mem[0] = 0xABCD`, RUN.
  - `sum` did not carry over from the aborted load.
- **Full depth.** Header 0xFF followed by 256 words where word i = {i, ~i}, then the correct checksum.
  - Required: `mem[255] = 0xFF00`, `mem[0] = 0x00FF`, RUN.
  - No early exit and no address wrap.
- **Processor write.** In RUN with `mem[5] = 0x2A00`, apply `adrs = 5`, `rw = 0`, `dout = 0x3C` for one edge.
  - Required: `mem[5] = 0x2A3C`.
  - The same write attempted in HDR leaves `mem[5]` unchanged.
